// File: rtl/gpu_lsu.sv
// Load/store unit between the GPU execute stage and the data BRAM.
// It accepts one request at a time and returns load data through a valid/ready writeback port.
//
// state    | meaning
// IDLE     | accepting requests; stores issue from here at one per cycle
// LD_ISSUE | ld_en high, memory is reading
// LD_CAPT  | ld_data valid, capture it into the response
// RESP     | response held until resp_ready
module gpu_lsu #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_err,
    output logic              ld_en,
    output logic [9:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              st_en,
    output logic [9:0]        st_addr,
    output logic [DATA_W-1:0] st_data,
    output logic              err_misalign,
    output logic [CNT_W-1:0]  ld_cnt,
    output logic [CNT_W-1:0]  st_cnt
);

    typedef enum logic [1:0] {IDLE, LD_ISSUE, LD_CAPT, RESP} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   aligned;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign aligned   = (req_addr[2:0] == 3'b000);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept && !req_is_store) state_nxt = aligned ? LD_ISSUE : RESP;
            LD_ISSUE: state_nxt = LD_CAPT;
            LD_CAPT:  state_nxt = RESP;
            RESP:     if (resp_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_tag     <= '0;
            resp_err     <= 1'b0;
            ld_en        <= 1'b0;
            ld_addr      <= '0;
            st_en        <= 1'b0;
            st_addr      <= '0;
            st_data      <= '0;
            err_misalign <= 1'b0;
            ld_cnt       <= '0;
            st_cnt       <= '0;
        end else begin
            // strobes are single-cycle pulses
            ld_en <= 1'b0;
            st_en <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (!aligned) begin
                        err_misalign <= 1'b1;
                        if (!req_is_store) begin
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_err   <= 1'b1;
                            resp_tag   <= req_tag;
                        end
                    end else if (req_is_store) begin
                        st_en   <= 1'b1;
                        st_addr <= req_addr[ADDR_W-1:3];
                        st_data <= req_wdata;
                        if (st_cnt != '1) st_cnt <= st_cnt + 1'b1;
                    end else begin
                        ld_en    <= 1'b1;
                        ld_addr  <= req_addr[ADDR_W-1:3];
                        resp_tag <= req_tag;
                        if (ld_cnt != '1) ld_cnt <= ld_cnt + 1'b1;
                    end
                end
                LD_CAPT: begin
                    resp_data  <= ld_data;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                end
                RESP: if (resp_ready) resp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
